// File: rtl/cache_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_mem_pkg: shared constants and FSM type for the line-fill memory.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cache_mem_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int DEF_LINE_BYTES = 128;
  localparam int DEF_BEATS      = DEF_LINE_BYTES / WORD_BYTES;
  localparam int BEAT_CNT_W     = $clog2(DEF_BEATS);
  localparam int LINE_OFF_W     = $clog2(DEF_LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    GAP  = 2'd3
  } refill_state_t;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_fill_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_fill_ram: single-port synchronous RAM, byte write enables.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module line_fill_ram
  import cache_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic                    re,
  input  logic [AW-1:0]           addr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  output logic [8*WORD_BYTES-1:0] rdata
);

  // One byte-wide array per lane keeps each lane's write enable independent.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    logic [7:0] mem [MEM_WORDS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (we && be[i]) begin
        mem[addr] <= wdata[8*i +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = rdata_q;
  end

endmodule
`default_nettype wire

// File: rtl/cache_refill_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_refill_responder: backing RAM that returns cache lines as beats.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_refill_responder
  import cache_mem_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 2,
  parameter int BEAT_GAP   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        wr_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_data_valid,
  output logic        mem_last,
  output logic        busy
);

  localparam int c_beats  = LINE_BYTES / WORD_BYTES;
  localparam int c_beat_w = cnt_width(c_beats);
  localparam int c_aw     = $clog2(MEM_WORDS);
  localparam int c_cnt_w  = cnt_width((LATENCY > BEAT_GAP) ? LATENCY : BEAT_GAP);

  localparam logic [31:0]         c_line_mask = 32'(LINE_BYTES - 1);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
  localparam logic [c_beat_w-1:0] c_beat_one  = c_beat_w'(1);
  localparam logic [c_cnt_w-1:0]  c_lat_init  = c_cnt_w'(LATENCY - 1);
  localparam logic [c_cnt_w-1:0]  c_gap_init  = c_cnt_w'(BEAT_GAP - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

  refill_state_t       state_q, state_d;
  logic [c_beat_w-1:0] beat_q, beat_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [31:0]         mem_addr_q, mem_addr_d;

  logic              w_req_fire;
  logic              w_wr_fire;
  logic              w_ram_re;
  logic [c_aw-1:0]   w_ram_addr;
  logic [31:0]       w_ram_rdata;
  logic              w_unused_addr_bits;

  assign w_req_fire = req_valid && req_ready;
  assign w_wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (w_req_fire) begin
          mem_addr_d = req_addr & ~c_line_mask;
          beat_d     = '0;
          cnt_d      = c_lat_init;
          // With a one-cycle latency the acceptance cycle itself issues the read.
          state_d    = (LATENCY == 1) ? BEAT : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= c_cnt_one) begin
          state_d = BEAT;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      BEAT: begin
        if (beat_q == c_last_beat) begin
          state_d = IDLE;
        end else begin
          mem_addr_d = mem_addr_q + 32'd4;
          beat_d     = beat_q + c_beat_one;
          cnt_d      = c_gap_init;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = BEAT;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    wr_ready       = 1'b0;
    mem_data_valid = 1'b0;
    mem_last       = 1'b0;
    busy           = 1'b1;
    case (state_q)
      IDLE: begin
        wr_ready  = 1'b1;
        req_ready = !wr_valid;
        busy      = 1'b0;
      end
      BEAT: begin
        mem_data_valid = 1'b1;
        mem_last       = (beat_q == c_last_beat);
      end
      default: ;
    endcase
  end

  // Reads happen only in the cycle before a beat and writes only in IDLE,
  // so the single RAM port is never contended.
  assign w_ram_re   = (state_d == BEAT);
  assign w_ram_addr = w_wr_fire ? wr_addr[c_aw+1:2] : mem_addr_d[c_aw+1:2];
  assign w_unused_addr_bits = ^{wr_addr[31:c_aw+2], wr_addr[1:0]};

  line_fill_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_wr_fire),
    .be    (wr_strb),
    .re    (w_ram_re),
    .addr  (w_ram_addr),
    .wdata (wr_data),
    .rdata (w_ram_rdata)
  );

  assign mem_addr = mem_addr_q;
  assign mem_data = w_ram_rdata;

endmodule
`default_nettype wire

// File: doc/cache_refill_responder.md
# cache_refill_responder

Memory-side responder for the cache line-fill interface. It accepts one line-refill request at a time from the cache, reads the line from an internal word-addressed backing RAM, and returns it as a burst of word beats. Each beat is a one-cycle `mem_data_valid` pulse, and `mem_last` marks the final beat. A single-word write port, used by the cache's write-through path, updates the same RAM, so the block serves as the backing memory under the cache in both RTL and formal benches.

## Interface
Parameters:
- `LINE_BYTES`, 128: cache line size. Power of two. Beats per line = `LINE_BYTES/4`.
- `MEM_WORDS`, 4096: backing RAM depth in 32-bit words. Power of two.
- `LATENCY`, 2: cycles from request acceptance to the first beat. Must be ≥ 1.
- `BEAT_GAP`, 1: idle cycles between beats. Must be ≥ 1, so `mem_data_valid` is never high on two consecutive cycles.

Ports:
- `clk` in 1: single clock. All logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: refill request.
- `req_addr` in 32: any byte address inside the requested line.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `wr_valid` in 1: word write request.
- `wr_addr` in 32: word-aligned write address. Bits [1:0] are ignored.
- `wr_data` in 32: write data.
- `wr_strb` in 4: byte enables. Bit i enables byte i (bits [8i+7:8i]).
- `wr_ready` out 1: write accepted on `wr_valid && wr_ready`.
- `mem_addr` out 32: address of the current or next beat.
- `mem_data` out 32: beat data. Connects to the cache's `mem_data_in`.
- `mem_data_valid` out 1: one-cycle beat strobe.
- `mem_last` out 1: final-beat marker.
- `busy` out 1: burst in progress.

## Operation
- FSM states: `IDLE`, `WAIT`, `BEAT`, `GAP`.
- `IDLE`:
  - `wr_ready = 1`.
  - `req_ready = !wr_valid`. A write has priority over a simultaneous request, so a later refill sees the written data.
- On write acceptance: RAM bytes with `wr_strb` set are updated at that edge. The state stays `IDLE`.
- On request acceptance:
  - `base = req_addr & ~(LINE_BYTES-1)`.
  - `mem_addr <= base`.
  - Beat counter ← 0.
  - Latency counter ← `LATENCY-1`.
  - Next state is `WAIT`.
- `WAIT`: counts down. At 0, go to `BEAT`.
- `BEAT`:
  - `mem_data_valid = 1` for exactly one cycle.
  - `mem_data = RAM[mem_addr[log2(MEM_WORDS)+1:2]]`.
  - `mem_last = 1` iff beat counter = `LINE_BYTES/4 - 1`.
  - After a non-last beat: `mem_addr += 4` and go to `GAP` for `BEAT_GAP` cycles, then back to `BEAT`.
  - After the last beat: `mem_addr` holds and the state returns to `IDLE`.
- RAM read is synchronous. The read address is presented in the cycle before each `BEAT`; `LATENCY ≥ 1` guarantees that cycle exists.
- Address width rules:
  - RAM index uses `mem_addr[log2(MEM_WORDS)+1:2]`. Higher bits alias (wrap modulo RAM size).
  - The 32-bit `mem_addr` increment never leaves the line, because `base` is aligned.
  - The beat counter is `log2(LINE_BYTES/4)` bits wide and reaches its maximum exactly on the last beat.
- `mem_data` changes only in cycles where `mem_data_valid` rises. It holds the last beat value otherwise.
- `mem_addr` changes only on acceptance or in the cycle after a non-last beat.
- `busy = (state != IDLE)`.
- No accesses are accepted while busy:
  - `req_ready = 0` and `wr_ready = 0`.
  - Held `req_valid` or `wr_valid` is serviced after the burst ends.

## Timing
- Request accepted at edge T. Beat k (k = 0..N-1, N = `LINE_BYTES/4`) has `mem_data_valid = 1` in cycle T + `LATENCY` + k·(`BEAT_GAP`+1).
- Defaults: beats in cycles T+2, T+4, …, T+64. The last beat is in cycle T+64.
- `busy` is high from cycle T+1 through the last-beat cycle.
- `req_ready` and `wr_ready` are high again in the cycle after the last beat. A back-to-back burst can therefore be accepted one cycle after `mem_last`.
- A write accepted at edge W is visible to a refill accepted at W+1 or later.
- Reset values:
  - `state = IDLE`.
  - `mem_addr = 0`, `mem_data = 0`.
  - `mem_data_valid = 0`, `mem_last = 0`, `busy = 0`.
  - `req_ready = 1`, `wr_ready = 1`.
  - RAM contents are not reset.
- Reset mid-burst: outputs take their reset values in the next cycle. No further beats are issued, `mem_last` is not emitted, and the partial burst is abandoned.

## Structure
- Shared package `cache_mem_pkg` holds:
  - `WORD_BYTES = 4`.
  - The default `LINE_BYTES`.
  - Beat-count and line-offset width constants.
  - The FSM enum `refill_state_t` {`IDLE`, `WAIT`, `BEAT`, `GAP`}.
- Sub-module `line_fill_ram`: single-port synchronous RAM, `MEM_WORDS`×32, per-byte write enables, one-cycle read latency.
- Address and beat counters, plus the FSM, live in the top module.

## Test plan
- Reset: assert `reset` for 2 cycles → every output at its reset value; `req_ready = 1`, `wr_ready = 1`.
- Basic burst:
  - Write `0xAAAAAAAA` to addresses 0x100–0x17C, then request `req_addr = 0x134`.
  - Required: 32 beats in cycles T+2, T+4, …, T+64.
  - `mem_addr` = 0x100, 0x104, …, 0x17C on the beats; all `mem_data = 0xAAAAAAAA`.
  - `mem_last` high only at T+64; `mem_addr` is 0x17C after the burst.
- Byte strobes: write `0x55555555` with `wr_strb = 4'b0011` to 0x108 (previously `0xAAAAAAAA`), then refill line 0x100 → beat 2 carries `0xAAAA5555`.
- Simultaneous request and write in `IDLE`:
  - Write to 0x200 is accepted with `req_ready = 0`.
  - The request is accepted the next cycle.
  - Beat 0 returns the newly written word.
- Reset at beat 10 → the next cycle shows `mem_data_valid = 0` and `busy = 0`, `mem_last` never asserts, and a new request is accepted with first beat at T'+2.
- `req_valid` held high through a burst → second request accepted in the cycle after `mem_last`. No beat overlap and no consecutive-cycle `mem_data_valid`.
